// File: rtl/alu_muldiv.sv
// RV32I/M integer execution unit: single-cycle base ALU plus an iterative
// shift-add multiplier and restoring divider behind a valid/ready handshake.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;

   // hi/lo hold product halves while multiplying, remainder/quotient while dividing.
   logic [WIDTH-1:0]   hi, lo, opd;
   logic [SHAMT_W-1:0] cnt;
   logic               neg_res, neg_rem, sel_hi;

   logic               is_op, is_imm, is_m, is_mul, is_div;
   logic               div_zero, div_ovf, div_long, fire;
   logic               a_signed, b_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, alu_res;
   logic [SHAMT_W-1:0] shamt;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, mul_prod;
   logic [WIDTH:0]     div_shift, div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   rem_next, quo_next, step_res;

   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign out_valid = (state == DONE);
   assign busy      = (state == MUL) || (state == DIV);
   assign fire      = in_valid && in_ready && !flush;

   assign is_op    = (opcode == OPC_OP);
   assign is_imm   = (opcode == OPC_IMM);
   assign is_m     = is_op && (funct7 == F7_M);
   assign is_mul   = is_m && !funct3[2];
   assign is_div   = is_m && funct3[2];
   assign div_zero = (op2 == '0);
   assign div_ovf  = !funct3[0] && (op1 == MOST_NEG) && (op2 == '1);
   assign div_long = is_div && !div_zero && !div_ovf;

   // MUL/MULH treat both operands as signed, MULHSU only op1; DIV/REM sign both.
   assign a_signed = funct3[2] ? !funct3[0] : (funct3 != 3'd3);
   assign b_signed = funct3[2] ? !funct3[0] : !funct3[1];
   assign a_neg    = a_signed && op1[WIDTH-1];
   assign b_neg    = b_signed && op2[WIDTH-1];
   assign a_mag    = a_neg ? -op1 : op1;
   assign b_mag    = b_neg ? -op2 : op2;
   assign shamt    = op2[SHAMT_W-1:0];

   // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
   always_comb begin
      alu_res = '0;
      if (is_m) begin
         if (funct3[2] && div_zero)     alu_res = funct3[1] ? op1 : '1;
         else if (funct3[2] && div_ovf) alu_res = funct3[1] ? '0 : op1;
      end else if (is_op || is_imm) begin
         case (funct3)
            3'd0: if (is_imm || funct7 == F7_BASE) alu_res = op1 + op2;
                  else if (funct7 == F7_ALT)       alu_res = op1 - op2;
            3'd1: if (funct7 == F7_BASE) alu_res = op1 << shamt;
            3'd2: if (is_imm || funct7 == F7_BASE)
                     alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            3'd3: if (is_imm || funct7 == F7_BASE)
                     alu_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            3'd4: if (is_imm || funct7 == F7_BASE) alu_res = op1 ^ op2;
            3'd5: if (funct7 == F7_BASE)     alu_res = op1 >> shamt;
                  else if (funct7 == F7_ALT) alu_res = $unsigned($signed(op1) >>> shamt);
            3'd6: if (is_imm || funct7 == F7_BASE) alu_res = op1 | op2;
            3'd7: if (is_imm || funct7 == F7_BASE) alu_res = op1 & op2;
            default: alu_res = '0;
         endcase
      end
   end

   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
   assign mul_next = {mul_sum, lo[WIDTH-1:1]};
   assign mul_prod = neg_res ? -mul_next : mul_next;

   // Rem < divisor before the shift, so the trial value fits in WIDTH+1 bits.
   assign div_shift = {hi, lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opd};
   assign div_ok    = !div_diff[WIDTH];
   assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign quo_next  = {lo[WIDTH-2:0], div_ok};

   always_comb begin
      step_res = '0;
      if (state == MUL)
         step_res = sel_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
      else if (sel_hi)
         step_res = neg_rem ? -rem_next : rem_next;
      else
         step_res = neg_res ? -quo_next : quo_next;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (state == DONE && out_ready) state_nxt = IDLE;
            if (fire) state_nxt = is_mul ? MUL : (div_long ? DIV : DONE);
         end
         MUL, DIV: if (cnt == LAST) state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // NOTE: datapath registers are reset too, so no X can leak out after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi      <= '0;
         lo      <= '0;
         opd     <= '0;
         cnt     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         sel_hi  <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
      end else if (fire) begin
         cnt     <= '0;
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
         sel_hi  <= is_mul ? (funct3 != 3'd0) : funct3[1];
         if (is_mul) begin
            hi  <= '0;
            lo  <= b_mag;
            opd <= a_mag;
         end else if (div_long) begin
            hi  <= '0;
            lo  <= a_mag;
            opd <= b_mag;
         end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
         end
      end else if (busy && !flush) begin
         cnt <= cnt + 1'b1;
         if (state == MUL) begin
            hi <= mul_next[2*WIDTH-1:WIDTH];
            lo <= mul_next[WIDTH-1:0];
         end else begin
            hi <= rem_next;
            lo <= quo_next;
         end
         if (cnt == LAST) begin
            result <= step_res;
            zero   <= (step_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_muldiv;

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] IMM = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_res(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
      int          sa, sb;
      logic [63:0] pr;
      logic        ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (opc == OP && f7 == 7'd1) begin
         case (f3)
            3'd0: begin pr = longint'(sa) * longint'(sb); return pr[31:0]; end
            3'd1: begin pr = longint'(sa) * longint'(sb); return pr[63:32]; end
            3'd2: begin pr = longint'(sa) * longint'({32'b0, b}); return pr[63:32]; end
            3'd3: begin pr = {32'b0, a} * {32'b0, b}; return pr[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
         endcase
      end
      if (opc == OP && f7 == 7'h20) begin
         if (f3 == 3'd0) return a - b;
         if (f3 == 3'd5) return 32'(sa >>> b[4:0]);
         return 32'd0;
      end
      if ((opc == OP && f7 == 7'd0) || opc == IMM) begin
         case (f3)
            3'd0: return a + b;
            3'd1: return (f7 == 7'd0) ? a << b[4:0] : 32'd0;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'd0) ? a >> b[4:0] : ((f7 == 7'h20) ? 32'(sa >>> b[4:0]) : 32'd0);
            3'd6: return a | b;
            default: return a & b;
         endcase
      end
      return 32'd0;
   endfunction

   function automatic int ref_lat(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a,
                                  input logic [31:0] b);
      if (opc != OP || f7 != 7'd1) return 1;
      if (f3 < 3'd4) return 33;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         4: return -32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op with out_ready high, scramble the inputs after acceptance,
   // then check latency, busy, result and zero.
   task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] exp;
      int          exp_lat, lat;
      logic        got, busy_bad;
      exp     = ref_res(opc, f3, f7, a, b);
      exp_lat = ref_lat(opc, f3, f7, a, b);
      @(negedge clk);
      opcode = opc; funct3 = f3; funct7 = f7; op1 = a; op2 = b;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
      lat = 0; got = 1'b0; busy_bad = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid === 1'b1) got = 1'b1;
         else if (busy !== 1'b1) busy_bad = 1'b1;
      end
      n_tests++;
      if (lat !== exp_lat || !got) begin
         n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_tests++;
      if (result !== exp) begin
         n_fail++; $display("FAIL %s result: got %h want %h (a=%h b=%h)", name, result, exp, a, b);
      end
      n_tests++;
      if (zero !== (exp == 32'd0)) begin
         n_fail++; $display("FAIL %s zero: got %b want %b", name, zero, exp == 32'd0);
      end
      if (exp_lat > 1) begin
         n_tests++;
         if (busy_bad) begin
            n_fail++; $display("FAIL %s busy: got low while computing, want high", name);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if ({out_valid, busy, zero, in_ready, result} !== {4'b0011, 32'd0}) begin
         n_fail++;
         $display("FAIL reset: got valid=%b busy=%b zero=%b rdy=%b res=%h want 0 0 1 1 0",
                  out_valid, busy, zero, in_ready, result);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op(OP, 3'd0, 7'h00, 32'd5, 32'd7, "add_5_7");
      run_op(OP, 3'd0, 7'h20, 32'd7, 32'd7, "sub_7_7");
      run_op(OP, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, "mulh_min_min");
      run_op(OP, 3'd4, 7'h01, -32'd7, 32'd2, "div_m7_2");
      run_op(OP, 3'd6, 7'h01, -32'd7, 32'd2, "rem_m7_2");
      run_op(OP, 3'd5, 7'h01, 32'd7, 32'd0, "divu_by_zero");
      run_op(OP, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run_op(OP, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
      run_op(OP, 3'd5, 7'h20, 32'h8000_00F0, 32'h0000_0024, "sra_shamt_mask");
      run_op(7'b1100011, 3'd0, 7'h00, 32'd1, 32'd2, "bad_opcode");
   endtask

   task automatic test_alu_random();
      logic [6:0] f7;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: f7 = 7'h20;
            1: f7 = 7'($urandom);
            default: f7 = 7'h00;
         endcase
         run_op(($urandom_range(0, 2) == 0) ? IMM : OP, 3'($urandom), f7,
                rand_operand(), rand_operand(), "alu_rand");
      end
   endtask

   task automatic test_mul_random();
      for (int i = 0; i < 16; i++)
         run_op(OP, 3'($urandom_range(0, 3)), 7'h01, rand_operand(), rand_operand(), "mul_rand");
   endtask

   task automatic test_div_random();
      for (int i = 0; i < 16; i++)
         run_op(OP, 3'($urandom_range(4, 7)), 7'h01, rand_operand(), rand_operand(), "div_rand");
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      opcode = OP; funct3 = 3'd0; funct7 = 7'h00; op1 = 32'd100; op2 = 32'd23;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if ({out_valid, in_ready, result} !== {2'b10, 32'd123}) begin
            n_fail++;
            $display("FAIL hold cycle %0d: got valid=%b rdy=%b res=%h want 1 0 0000007b",
                     i, out_valid, in_ready, result);
         end
      end
      opcode = OP; funct3 = 3'd0; funct7 = 7'h20; op1 = 32'd50; op2 = 32'd8;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold release in_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({out_valid, result} !== {1'b1, 32'd42}) begin
         n_fail++; $display("FAIL hold next op: got valid=%b res=%h want 1 0000002a", out_valid, result);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, exp;
      int          lat;
      a = rand_operand(); b = rand_operand();
      exp = ref_res(OP, 3'd3, 7'h01, a, b);
      @(negedge clk);
      opcode = IMM; funct3 = 3'd6; funct7 = 7'h00; op1 = 32'hF0; op2 = 32'h0F;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({out_valid, result} !== {1'b1, 32'hFF}) begin
         n_fail++; $display("FAIL b2b first: got valid=%b res=%h want 1 000000ff", out_valid, result);
      end
      opcode = OP; funct3 = 3'd3; funct7 = 7'h01; op1 = a; op2 = b; in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b in_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk); lat++;
      end while (out_valid !== 1'b1 && lat < 100);
      n_tests++;
      if ({lat, result} !== {32'd33, exp}) begin
         n_fail++; $display("FAIL b2b mulhu: got lat=%0d res=%h want 33 %h", lat, result, exp);
      end
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      opcode = OP; funct3 = 3'd4; funct7 = 7'h01; op1 = 32'd1000; op2 = 32'd7;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         n_fail++; $display("FAIL flush mid-div: got valid=%b busy=%b rdy=%b want 0 0 1",
                            out_valid, busy, in_ready);
      end
      seen = 0;
      repeat (40) @(negedge clk) if (out_valid !== 1'b0) seen++;
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL flush discard: got %0d valid cycles want 0", seen);
      end
      @(negedge clk);
      opcode = OP; funct3 = 3'd4; funct7 = 7'h00; op1 = 32'd3; op2 = 32'd5;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk) flush = 1'b1;
      opcode = OP; funct3 = 3'd0; funct7 = 7'h00; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
      @(negedge clk);
      n_tests++;
      if ({out_valid, busy} !== 2'b00) begin
         n_fail++; $display("FAIL flush priority: got valid=%b busy=%b want 0 0", out_valid, busy);
      end
      run_op(OP, 3'd5, 7'h01, 32'd1000, 32'd7, "after_flush");
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      opcode = OP; funct3 = 3'd1; funct7 = 7'h01; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, busy, zero, result} !== {3'b001, 32'd0}) begin
         n_fail++; $display("FAIL reset mid-mul: got valid=%b busy=%b zero=%b res=%h want 0 0 1 0",
                            out_valid, busy, zero, result);
      end
      @(negedge clk) rst_n = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset release in_ready: got %b want 1", in_ready);
      end
      seen = 0;
      repeat (40) @(negedge clk) if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL reset abandon: got %0d active cycles want 0", seen);
      end
      run_op(OP, 3'd1, 7'h01, 32'h1234_5678, 32'h9ABC_DEF0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_alu_random();
      test_mul_random();
      test_div_random();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
